bin2bcd_seq: RTL

Sequential signed-binary-to-BCD converter that sits directly upstream of the seven-segment decoders. It accepts a two's-complement result from the datapath, splits off the sign, and converts the magnitude to packed BCD digits using an iterative shift-and-add-3 (double-dabble) loop, one bit per clock. Each BCD nibble drives one decoder's digit input, and `neg` drives the decoders' sign input.

---
 rtl/bin2bcd_if.sv | 16 +
 rtl/bin2bcd_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/bin2bcd_if.sv
// Handshake and result bundle between the datapath and the BCD converter.
// The master drives start/value; the slave returns status and packed BCD digits.
interface bin2bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;

  modport master (output start, value, input busy, done, bcd, neg);
  modport slave  (input start, value, output busy, done, bcd, neg);
endinterface

// File: rtl/bin2bcd_seq.sv
// Signed binary to packed BCD, one double-dabble iteration per clock.
// Sign is split off at capture; the magnitude is shifted through the scratch digits.

// One BCD nibble's pre-shift correction: add 3 when the digit would overflow on doubling.
module bin2bcd_digit (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;
endmodule

module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  bin2bcd_if.slave    bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t                    state_q;
  logic [CW-1:0]             cnt_q;
  logic [WIDTH-1:0]          mag_q;
  logic                      sign_q;
  logic [DIGITS-1:0][3:0]    scr_q;
  logic [BW-1:0]             bcd_q;
  logic                      neg_q;
  logic                      busy_q;
  logic                      done_q;

  logic [DIGITS-1:0][3:0]    adj;
  logic [BW-1:0]             adj_flat;
  logic [DIGITS-1:0][3:0]    scr_d;
  logic [WIDTH-1:0]          mag_d;
  logic [WIDTH-1:0]          neg_mag;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bin2bcd_digit u_dig (
      .d_i (scr_q[g]),
      .d_o (adj[g])
    );
  end

  // Most negative input wraps to 2^(WIDTH-1), which reads correctly as unsigned.
  assign neg_mag  = ~bus.value + {{(WIDTH-1){1'b0}}, 1'b1};
  assign adj_flat = adj;
  assign scr_d    = {adj_flat[BW-2:0], mag_q[WIDTH-1]};
  assign mag_d    = {mag_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      scr_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sign_q  <= bus.value[WIDTH-1];
            mag_q   <= bus.value[WIDTH-1] ? neg_mag : bus.value;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          scr_q <= scr_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            bcd_q   <= scr_d;
            neg_q   <= sign_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.neg  = neg_q;
endmodule
